// File: rtl/rx_serial_7n2_pkg.sv
// Shared definitions for the 7N2 serial receiver.
// Purpose: FSM state codes (4-bit, shown on the debug hex display) and
//   the baud-rate constants for the two supported line speeds.
// Ports: none (package).
package rx_serial_7n2_pkg;

  // Clock cycles per bit and bit-timer width at 50 MHz.
  localparam int M_115200 = 434;
  localparam int N_115200 = 9;
  localparam int M_9600   = 5208;
  localparam int N_9600   = 13;

  localparam int DATA_BITS = 7;

  // The numeric values double as the db_estado debug code.
  typedef enum logic [3:0] {
    INICIAL        = 4'h0,
    START          = 4'h1,
    DADOS          = 4'h2,
    STOP1          = 4'h3,
    STOP2          = 4'h4,
    ARMAZENA       = 4'h5,
    ERRO           = 4'hE,
    ESPERA_REPOUSO = 4'hF
  } state_t;

endpackage

// File: rtl/rx_serial_7n2_fd.sv
// Datapath of the 7N2 serial receiver.
// Purpose: synchronises the serial line, runs the bit timer, shifts in the
//   data bits, counts them and holds the last good word.
// Ports:
//   clock_i, reset_i  clock and synchronous active-high reset
//   serial_i          raw serial line (asynchronous)
//   zera_i            clear bit timer and bit counter
//   desloca_i         shift rx_s into the shift register MSB
//   conta_i           increment the bit counter
//   registra_i        copy the shift register to the output register
//   rx_s_o            synchronised serial line
//   meio_o, tick_o    mid-bit and end-of-period strobes of the bit timer
//   fim_o             the bit currently being sampled is the last data bit
//   dados_o           last correctly received word
module rx_serial_7n2_fd
  import rx_serial_7n2_pkg::*;
#(
  parameter int M = M_115200,
  parameter int N = N_115200
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 serial_i,
  input  logic                 zera_i,
  input  logic                 desloca_i,
  input  logic                 conta_i,
  input  logic                 registra_i,
  output logic                 rx_s_o,
  output logic                 meio_o,
  output logic                 tick_o,
  output logic                 fim_o,
  output logic [DATA_BITS-1:0] dados_o
);

  localparam logic [N-1:0] MEIO_VAL = N'(M / 2 - 1);
  localparam logic [N-1:0] TICK_VAL = N'(M - 1);

  logic                 sync1_q, sync2_q;
  logic [N-1:0]         timer_q, timer_d;
  logic [2:0]           count_q, count_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] dados_q, dados_d;

  assign rx_s_o  = sync2_q;
  assign meio_o  = (timer_q == MEIO_VAL);
  assign tick_o  = (timer_q == TICK_VAL);
  // The counter has already been bumped once per earlier data bit, so a
  // value of DATA_BITS-1 means the tick in progress samples the last bit.
  assign fim_o   = (count_q == 3'(DATA_BITS - 1));
  assign dados_o = dados_q;

  // Bits arrive LSB first, so each new bit enters at the MSB and after
  // DATA_BITS shifts the first bit has reached bit 0.
  always_comb begin
    timer_d = timer_q + 1'b1;
    if (zera_i || tick_o) timer_d = '0;
    count_d = count_q;
    if (zera_i)       count_d = '0;
    else if (conta_i) count_d = count_q + 3'd1;
    shift_d = shift_q;
    if (desloca_i) shift_d = {sync2_q, shift_q[DATA_BITS-1:1]};
    dados_d = dados_q;
    if (registra_i) dados_d = shift_q;
  end

  // The synchroniser resets to the idle (high) line level so that leaving
  // reset never looks like a start bit.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      timer_q <= '0;
      count_q <= '0;
      shift_q <= '0;
      dados_q <= '0;
    end else begin
      sync1_q <= serial_i;
      sync2_q <= sync1_q;
      timer_q <= timer_d;
      count_q <= count_d;
      shift_q <= shift_d;
      dados_q <= dados_d;
    end
  end

endmodule

// File: rtl/rx_serial_7n2_uc.sv
// Control unit of the 7N2 serial receiver.
// Purpose: frame-level FSM; all outputs are registered.
// Ports:
//   clock_i, reset_i        clock and synchronous active-high reset
//   rx_s_i                  synchronised serial line
//   meio_i, tick_i, fim_i   timer strobes and last-data-bit flag
//   zera_o ... registra_o   datapath controls
//   pronto_o, erro_o        frame received / framing error pulses
//   estado_o                current state code
module rx_serial_7n2_uc
  import rx_serial_7n2_pkg::*;
(
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       rx_s_i,
  input  logic       meio_i,
  input  logic       tick_i,
  input  logic       fim_i,
  output logic       zera_o,
  output logic       desloca_o,
  output logic       conta_o,
  output logic       registra_o,
  output logic       pronto_o,
  output logic       erro_o,
  output logic [3:0] estado_o
);

  state_t state_q;
  logic   zera_q, desloca_q, conta_q, registra_q, pronto_q, erro_q;

  assign zera_o     = zera_q;
  assign desloca_o  = desloca_q;
  assign conta_o    = conta_q;
  assign registra_o = registra_q;
  assign pronto_o   = pronto_q;
  assign erro_o     = erro_q;
  assign estado_o   = state_q;

  // Controls are registered, so each takes effect one cycle after the
  // decision. In INICIAL the timer is held at zero while the line is idle
  // and released on the very cycle the start bit is seen, which keeps the
  // mid-start sample centred. registra is raised on the mid-stop2 tick so
  // the word is loaded at the end of ARMAZENA, and pronto (raised in
  // ARMAZENA) then appears together with the new dados_ascii.
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q    <= ESPERA_REPOUSO;
      zera_q     <= 1'b0;
      desloca_q  <= 1'b0;
      conta_q    <= 1'b0;
      registra_q <= 1'b0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      zera_q     <= 1'b0;
      desloca_q  <= 1'b0;
      conta_q    <= 1'b0;
      registra_q <= 1'b0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
      case (state_q)
        ESPERA_REPOUSO: if (rx_s_i) state_q <= INICIAL;
        INICIAL: begin
          zera_q <= rx_s_i;
          if (!rx_s_i) state_q <= START;
        end
        START: begin
          if (meio_i) begin
            if (!rx_s_i) begin
              zera_q  <= 1'b1;
              state_q <= DADOS;
            end else begin
              state_q <= INICIAL;
            end
          end
        end
        DADOS: begin
          if (tick_i) begin
            desloca_q <= 1'b1;
            conta_q   <= 1'b1;
            if (fim_i) state_q <= STOP1;
          end
        end
        STOP1: if (tick_i) state_q <= rx_s_i ? STOP2 : ERRO;
        STOP2: begin
          if (tick_i) begin
            if (rx_s_i) begin
              registra_q <= 1'b1;
              state_q    <= ARMAZENA;
            end else begin
              state_q <= ERRO;
            end
          end
        end
        ARMAZENA: begin
          pronto_q <= 1'b1;
          state_q  <= INICIAL;
        end
        ERRO: begin
          erro_q  <= 1'b1;
          state_q <= ESPERA_REPOUSO;
        end
        default: state_q <= ESPERA_REPOUSO;
      endcase
    end
  end

endmodule

// File: rtl/rx_serial_7n2.sv
// Asynchronous serial receiver, 7 data bits, no parity, 2 stop bits, LSB first.
// Purpose: samples dados_serial at mid-bit, rebuilds the 7-bit ASCII word,
//   pulses pronto on a good frame and erro on a framing error.
// Ports:
//   clock, reset      50 MHz clock, synchronous active-high reset
//   dados_serial      serial line, idle high
//   dados_ascii       last correctly received word
//   pronto, erro      one-cycle frame-ok / framing-error pulses
//   db_tick           bit-timer sample strobe
//   db_dados_serial   synchronised serial input
//   db_estado         FSM state code
module rx_serial_7n2
  import rx_serial_7n2_pkg::*;
#(
  parameter int M = M_115200,
  parameter int N = N_115200
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 dados_serial,
  output logic [DATA_BITS-1:0] dados_ascii,
  output logic                 pronto,
  output logic                 erro,
  output logic                 db_tick,
  output logic                 db_dados_serial,
  output logic [3:0]           db_estado
);

  logic rxS, meio, tick, fim;
  logic zera, desloca, conta, registra;

  rx_serial_7n2_fd #(.M(M), .N(N)) u_fd (
    .clock_i    (clock),
    .reset_i    (reset),
    .serial_i   (dados_serial),
    .zera_i     (zera),
    .desloca_i  (desloca),
    .conta_i    (conta),
    .registra_i (registra),
    .rx_s_o     (rxS),
    .meio_o     (meio),
    .tick_o     (tick),
    .fim_o      (fim),
    .dados_o    (dados_ascii)
  );

  rx_serial_7n2_uc u_uc (
    .clock_i    (clock),
    .reset_i    (reset),
    .rx_s_i     (rxS),
    .meio_i     (meio),
    .tick_i     (tick),
    .fim_i      (fim),
    .zera_o     (zera),
    .desloca_o  (desloca),
    .conta_o    (conta),
    .registra_o (registra),
    .pronto_o   (pronto),
    .erro_o     (erro),
    .estado_o   (db_estado)
  );

  assign db_tick         = tick;
  assign db_dados_serial = rxS;

endmodule

// File: tb/tb_rx_serial_7n2.sv
// Testbench for rx_serial_7n2.
// Purpose: drives directed 7N2 frames into a fast instance (M=8) and one
//   frame into a full-rate instance (M=434); a monitor compares every
//   pronto/erro pulse against a queue of expected events.
module tb_rx_serial_7n2;

  localparam int M = 8;
  localparam int N = 4;
  localparam int MF = 434;

  typedef struct {
    bit         isErr;
    logic [6:0] data;
  } exp_t;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       serial = 1'b1;
  logic [6:0] dadosAscii;
  logic       pronto, erro, dbTick, dbSerial;
  logic [3:0] dbEstado;

  logic       serialF = 1'b1;
  logic [6:0] dadosAsciiF;
  logic       prontoF, erroF, dbTickF, dbSerialF;
  logic [3:0] dbEstadoF;

  int   nCompared = 0;
  int   nMismatched = 0;
  int   cyc = 0;
  int   lastPronto = 0;
  int   prevPronto = 0;
  logic [6:0] lastData = 7'h00;
  exp_t expQ[$];

  rx_serial_7n2 #(.M(M), .N(N)) u_dut (
    .clock           (clock),
    .reset           (reset),
    .dados_serial    (serial),
    .dados_ascii     (dadosAscii),
    .pronto          (pronto),
    .erro            (erro),
    .db_tick         (dbTick),
    .db_dados_serial (dbSerial),
    .db_estado       (dbEstado)
  );

  rx_serial_7n2 #(.M(MF), .N(9)) u_dutFull (
    .clock           (clock),
    .reset           (reset),
    .dados_serial    (serialF),
    .dados_ascii     (dadosAsciiF),
    .pronto          (prontoF),
    .erro            (erroF),
    .db_tick         (dbTickF),
    .db_dados_serial (dbSerialF),
    .db_estado       (dbEstadoF)
  );

  // 50 MHz-style clock; the period value itself is irrelevant to the design.
  always #5 clock = ~clock;

  // Posedge counter used for latency and spacing measurements.
  always @(posedge clock) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input int actual, input int expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
    end
  endtask

  task automatic checkRange(input string name, input int actual, input int lo, input int hi);
    nCompared++;
    if (actual < lo || actual > hi) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, want %0d..%0d", name, actual, lo, hi);
    end
  endtask

  task automatic pushExp(input bit isErr, input logic [6:0] data);
    exp_t e;
    e.isErr = isErr;
    e.data  = data;
    expQ.push_back(e);
  endtask

  // Sends one frame on the fast line: start, 7 data bits LSB first, stop1,
  // stop2, each M cycles long. Must be called on a negative edge.
  task automatic applyStimulus(input logic [6:0] data, input logic stop1, input logic stop2);
    logic [9:0] frame;
    frame = {stop2, stop1, data, 1'b0};
    for (int i = 0; i < 10; i++) begin
      serial = frame[i];
      repeat (M) @(negedge clock);
    end
  endtask

  // Monitor: every pronto/erro pulse of the fast DUT pops one expected event
  // and compares the kind of event and the word on dados_ascii.
  always @(negedge clock) begin
    if (!reset && (pronto || erro)) begin
      if (pronto && erro) begin
        checkOutput("pronto_and_erro", 1, 0);
      end
      if (pronto) begin
        prevPronto = lastPronto;
        lastPronto = cyc;
      end
      if (expQ.size() == 0) begin
        checkOutput("unexpected_event", int'({pronto, erro}), 0);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        checkOutput("event_erro", int'(erro), int'(e.isErr));
        checkOutput("event_pronto", int'(pronto), int'(!e.isErr));
        checkOutput("event_data", int'(dadosAscii), int'(e.data));
      end
    end
  end

  // Directed sequence of scenarios followed by the full-rate latency check.
  initial begin
    int t0;
    int t1;
    int t2;
    logic [9:0] frame;

    $display("[TB] start");
    repeat (3) @(negedge clock);
    checkOutput("reset_dados", int'(dadosAscii), 0);
    checkOutput("reset_pronto", int'(pronto), 0);
    checkOutput("reset_erro", int'(erro), 0);
    checkOutput("reset_estado", int'(dbEstado), 'hF);
    checkOutput("reset_sync", int'(dbSerial), 1);
    reset = 1'b0;
    repeat (5) @(negedge clock);
    checkOutput("idle_estado", int'(dbEstado), 'h0);

    // 1: 'A'
    pushExp(1'b0, 7'h41);
    applyStimulus(7'h41, 1'b1, 1'b1);
    lastData = 7'h41;
    repeat (M) @(negedge clock);

    // 2: back-to-back 0x7F then 0x00
    pushExp(1'b0, 7'h7F);
    pushExp(1'b0, 7'h00);
    applyStimulus(7'h7F, 1'b1, 1'b1);
    applyStimulus(7'h00, 1'b1, 1'b1);
    lastData = 7'h00;
    repeat (M) @(negedge clock);
    checkOutput("b2b_spacing", lastPronto - prevPronto, 10 * M);

    // 3: short low glitch on an idle line
    serial = 1'b0;
    repeat (M / 4) @(negedge clock);
    serial = 1'b1;
    repeat (2 * M) @(negedge clock);
    checkOutput("glitch_estado", int'(dbEstado), 'h0);
    checkOutput("glitch_dados", int'(dadosAscii), int'(lastData));

    // 4: 0x55 with a bad stop1, then a good 0x2A
    pushExp(1'b1, lastData);
    applyStimulus(7'h55, 1'b0, 1'b1);
    checkOutput("err_dados_kept", int'(dadosAscii), int'(lastData));
    pushExp(1'b0, 7'h2A);
    applyStimulus(7'h2A, 1'b1, 1'b1);
    lastData = 7'h2A;
    repeat (M) @(negedge clock);

    // 5: reset in the middle of the data bits of 0x33
    frame = {2'b11, 7'h33, 1'b0};
    for (int i = 0; i < 4; i++) begin
      serial = frame[i];
      repeat (M) @(negedge clock);
    end
    checkOutput("mid_frame_estado", int'(dbEstado), 'h2);
    serial = 1'b1;
    reset  = 1'b1;
    repeat (2) @(negedge clock);
    reset  = 1'b0;
    lastData = 7'h00;
    @(negedge clock);
    checkOutput("reset_mid_dados", int'(dadosAscii), 0);
    repeat (2 * M) @(negedge clock);
    pushExp(1'b0, 7'h33);
    applyStimulus(7'h33, 1'b1, 1'b1);
    lastData = 7'h33;
    repeat (M) @(negedge clock);

    // 6: full-rate instance, 0x4B, latency and tick period
    frame = {2'b11, 7'h4B, 1'b0};
    t0 = cyc + 1;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          serialF = frame[i];
          repeat (MF) @(negedge clock);
        end
      end
      begin
        for (int c = 0; c < 6000 && !prontoF; c++) @(negedge clock);
        if (prontoF) begin
          checkRange("full_latency", cyc - t0, 3 + MF / 2 + 9 * MF - 1, 3 + MF / 2 + 9 * MF + 1);
          checkOutput("full_data", int'(dadosAsciiF), 'h4B);
        end else begin
          checkOutput("full_pronto_timeout", 0, 1);
        end
      end
      begin
        repeat (2 * MF) @(negedge clock);
        t1 = 0;
        t2 = 0;
        for (int c = 0; c < 1000 && !dbTickF; c++) @(negedge clock);
        t1 = cyc;
        @(negedge clock);
        for (int c = 0; c < 1000 && !dbTickF; c++) @(negedge clock);
        t2 = cyc;
        checkOutput("full_tick_period", t2 - t1, MF);
      end
    join

    for (int c = 0; c < 100 && expQ.size() != 0; c++) @(negedge clock);
    checkOutput("queue_drained", expQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
